// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the fetch/data memory port arbiter.
// State codes, port identifiers and the latency ceiling.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2
    } arb_state_e;

    localparam logic ARB_PORT_IF = 1'b0;
    localparam logic ARB_PORT_DM = 1'b1;

    localparam int ARB_MAX_LAT = 4;

endpackage

// File: rtl/arb_rr2.sv
// Two-requester round-robin picker, purely combinational.
// req_i[1:0] requests, last_i = last granted index, grant_o one-hot.
module arb_rr2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = 2'b00;
        if (req_i[0] && req_i[1]) begin
            // Contention: the requester that did not win last time.
            grant_o = last_i ? 2'b01 : 2'b10;
        end else if (req_i[0]) begin
            grant_o = 2'b01;
        end else if (req_i[1]) begin
            grant_o = 2'b10;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous memory between the fetch (if_*) and data (dm_*) ports.
// Ports: if_* fetch, dm_* data, mem_* registered memory side, clk/rst (async low).
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_ce_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic [DATA_W-1:0]   if_data_o,
    output logic                if_stall_o,
    input  logic                dm_ce_i,
    input  logic                dm_we_i,
    input  logic [DATA_W/8-1:0] dm_sel_i,
    input  logic [ADDR_W-1:0]   dm_addr_i,
    input  logic [DATA_W-1:0]   dm_wdata_i,
    output logic [DATA_W-1:0]   dm_rdata_o,
    output logic                dm_stall_o,
    output logic                mem_ce_o,
    output logic                mem_we_o,
    output logic [DATA_W/8-1:0] mem_sel_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    input  logic [DATA_W-1:0]   mem_rdata_i
);

    localparam int SEL_W = DATA_W / 8;
    localparam logic [2:0] LAT = 3'(MEM_LAT);

    arb_state_e        state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic [2:0]        lat_q, lat_d;
    logic [1:0]        done_q, done_d;
    logic              ce_q, ce_d;
    logic              we_q, we_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] ifd_q, ifd_d;
    logic [DATA_W-1:0] dmd_q, dmd_d;
    logic [1:0]        elig;
    logic [1:0]        grant;

    // A port that just completed sits out one cycle so the CPU can
    // advance its request without being granted a duplicate.
    assign elig = {dm_ce_i, if_ce_i} & ~done_q;

    arb_rr2 u_rr (
        .req_i   (elig),
        .last_i  (last_q),
        .grant_o (grant)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        lat_d   = lat_q;
        done_d  = 2'b00;
        ce_d    = ce_q;
        we_d    = we_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ifd_d   = ifd_q;
        dmd_d   = dmd_q;
        unique case (state_q)
            ARB_IDLE: begin
                unique case (1'b1)
                    grant[ARB_PORT_DM]: begin
                        state_d = ARB_ISSUE;
                        owner_d = ARB_PORT_DM;
                        last_d  = ARB_PORT_DM;
                        lat_d   = 3'd0;
                        ce_d    = 1'b1;
                        we_d    = dm_we_i;
                        sel_d   = dm_sel_i;
                        addr_d  = dm_addr_i;
                        wdata_d = dm_wdata_i;
                    end
                    grant[ARB_PORT_IF]: begin
                        state_d = ARB_ISSUE;
                        owner_d = ARB_PORT_IF;
                        last_d  = ARB_PORT_IF;
                        lat_d   = 3'd0;
                        ce_d    = 1'b1;
                        we_d    = 1'b0;
                        sel_d   = '1;
                        addr_d  = if_addr_i;
                        wdata_d = '0;
                    end
                    default: ;
                endcase
            end
            ARB_ISSUE: begin
                ce_d    = 1'b0;
                lat_d   = lat_q + 3'd1;
                state_d = ARB_WAIT;
            end
            ARB_WAIT: begin
                if (lat_q == LAT) begin
                    if (!we_q) begin
                        if (owner_q == ARB_PORT_DM) dmd_d = mem_rdata_i;
                        else ifd_d = mem_rdata_i;
                    end
                    done_d[owner_q] = 1'b1;
                    state_d = ARB_IDLE;
                end else begin
                    lat_d = lat_q + 3'd1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ARB_IDLE;
            owner_q <= ARB_PORT_IF;
            last_q  <= ARB_PORT_IF;
            lat_q   <= 3'd0;
            done_q  <= 2'b00;
            ce_q    <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            ifd_q   <= '0;
            dmd_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            lat_q   <= lat_d;
            done_q  <= done_d;
            ce_q    <= ce_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ifd_q   <= ifd_d;
            dmd_q   <= dmd_d;
        end
    end

    assign if_stall_o  = if_ce_i & ~done_q[ARB_PORT_IF];
    assign dm_stall_o  = dm_ce_i & ~done_q[ARB_PORT_DM];
    assign if_data_o   = ifd_q;
    assign dm_rdata_o  = dmd_q;
    assign mem_ce_o    = ce_q;
    assign mem_we_o    = we_q;
    assign mem_sel_o   = sel_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;

endmodule
